// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed number of wait states and a one-cycle Ack.
// Latency: good request acks WAIT_CYCLES+2 cycles after capture cycle; rejected request acks after 1.
// Backpressure: Busy is high from capture until Ack; Req is ignored while Busy.
module data_mem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        WrEn,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        Ack,
    output logic        Err,
    output logic        Busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic                    wr_q;
    logic                    err_q;
    logic                    req_bad;
    logic                    access;
    logic [31:0]             mem [DEPTH];

    // Misaligned or beyond the last word: rejected without touching memory.
    assign req_bad = (Addr[1:0] != 2'b00) || ((Addr >> (DEPTH_LOG2 + 2)) != 32'd0);

    always_comb begin
        state_d = state_q;
        access  = 1'b0;
        case (state_q)
            S_IDLE: if (Req) state_d = req_bad ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            RData   <= 32'd0;
        end else begin
            if (state_q == S_IDLE && Req) begin
                idx_q   <= Addr[DEPTH_LOG2+1:2];
                wdata_q <= WData;
                wr_q    <= WrEn;
                err_q   <= req_bad;
                cnt_q   <= 4'(WAIT_CYCLES);
            end
            if (state_q == S_WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
            if (access && !wr_q) RData <= mem[idx_q];
        end
    end

    // Array is deliberately unreset; a reset before the commit edge drops the store.
    always_ff @(posedge Clk) begin
        if (access && wr_q) mem[idx_q] <= wdata_q;
    end

    assign Ack  = (state_q == S_RESP);
    assign Err  = Ack && err_q;
    assign Busy = (state_q != S_IDLE);

endmodule
